// File: rtl/sobel_edge_param_if.sv
// Pixel stream bundle for the Sobel edge detector: grey input stream, runtime
// controls, and the delayed result stream.
interface sobel_edge_param_if #(
  parameter int DW = 8
);
  logic [DW-1:0] i_data;
  logic          i_de;
  logic          i_vs;
  logic [DW+2:0] threshold;
  logic [1:0]    mode;
  logic          invert;
  logic [DW-1:0] o_data;
  logic          o_edge;
  logic          o_de;
  logic          o_vs;

  modport master (
    output i_data, i_de, i_vs, threshold, mode, invert,
    input  o_data, o_edge, o_de, o_vs
  );

  modport slave (
    input  i_data, i_de, i_vs, threshold, mode, invert,
    output o_data, o_edge, o_de, o_vs
  );
endinterface

// File: rtl/sobel_edge_param.sv
// Streaming 3x3 Sobel edge detector with two internal line buffers and a fixed
// four-cycle latency; emits binary, saturated-magnitude or passthrough pixels.
module sobel_edge_param #(
  parameter int DW    = 8,
  parameter int IMG_W = 320,
  parameter int IMG_H = 720
) (
  input logic               sclk,
  input logic               rst,
  sobel_edge_param_if.slave bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int GW = DW + 4;
  localparam int AW = DW + 2;
  localparam int MW = DW + 3;

  logic [DW-1:0] lineA_q [IMG_W];
  logic [DW-1:0] lineB_q [IMG_W];
  logic [DW-1:0] win_q [3][3];

  logic [CW-1:0] col_q, col_d, pixCol;
  logic [RW-1:0] row_q, row_d, pixRow;
  logic          vsPrev_q, vsRise;

  logic          de1_q, vs1_q, border1_q;
  logic [DW-1:0] data1_q;
  logic          de2_q, vs2_q, border2_q;
  logic [DW-1:0] data2_q;
  logic signed [GW-1:0] gx_q, gy_q, gx_d, gy_d;
  logic          de3_q, vs3_q, border3_q;
  logic [DW-1:0] data3_q;
  logic [AW-1:0] absX_q, absY_q;

  logic [DW-1:0] oData_q;
  logic          oEdge_q, oDe_q, oVs_q;
  logic [MW-1:0] mag;
  logic          edgeHit;
  logic [DW-1:0] satMag;

  function automatic logic signed [GW-1:0] px(input logic [DW-1:0] p);
    return $signed({4'b0000, p});
  endfunction

  // A frame-start edge retargets the current pixel to (0,0) before it advances.
  always_comb begin
    vsRise = bus.i_vs & ~vsPrev_q;
    pixCol = vsRise ? '0 : col_q;
    pixRow = vsRise ? '0 : row_q;
    col_d  = pixCol;
    row_d  = pixRow;
    if (bus.i_de) begin
      if (pixCol == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (pixRow == RW'(IMG_H - 1)) ? '0 : pixRow + RW'(1);
      end else begin
        col_d = pixCol + CW'(1);
      end
    end
  end

  always_ff @(posedge sclk) begin
    if (bus.i_de) begin
      lineA_q[pixCol] <= bus.i_data;
      lineB_q[pixCol] <= lineA_q[pixCol];
    end
  end

  always_comb begin
    gx_d = (px(win_q[0][2]) - px(win_q[0][0]))
         + ((px(win_q[1][2]) - px(win_q[1][0])) <<< 1)
         + (px(win_q[2][2]) - px(win_q[2][0]));
    gy_d = (px(win_q[2][0]) + (px(win_q[2][1]) <<< 1) + px(win_q[2][2]))
         - (px(win_q[0][0]) + (px(win_q[0][1]) <<< 1) + px(win_q[0][2]));
  end

  always_comb begin
    mag     = MW'(absX_q) + MW'(absY_q);
    edgeHit = (mag >= bus.threshold);
    satMag  = (mag > MW'((1 << DW) - 1)) ? '1 : mag[DW-1:0];
  end

  // Window and counters only move on valid pixels; the pipeline always drains.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      col_q     <= '0;
      row_q     <= '0;
      vsPrev_q  <= 1'b0;
      win_q     <= '{default: '0};
      de1_q     <= 1'b0;
      vs1_q     <= 1'b0;
      border1_q <= 1'b0;
      data1_q   <= '0;
      de2_q     <= 1'b0;
      vs2_q     <= 1'b0;
      border2_q <= 1'b0;
      data2_q   <= '0;
      gx_q      <= '0;
      gy_q      <= '0;
      de3_q     <= 1'b0;
      vs3_q     <= 1'b0;
      border3_q <= 1'b0;
      data3_q   <= '0;
      absX_q    <= '0;
      absY_q    <= '0;
      oData_q   <= '0;
      oEdge_q   <= 1'b0;
      oDe_q     <= 1'b0;
      oVs_q     <= 1'b0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      vsPrev_q <= bus.i_vs;
      if (bus.i_de) begin
        for (int r = 0; r < 3; r++) begin
          for (int c = 0; c < 2; c++) begin
            win_q[r][c] <= win_q[r][c+1];
          end
        end
        win_q[0][2] <= lineB_q[pixCol];
        win_q[1][2] <= lineA_q[pixCol];
        win_q[2][2] <= bus.i_data;
      end
      de1_q     <= bus.i_de;
      vs1_q     <= bus.i_vs;
      data1_q   <= bus.i_data;
      border1_q <= (pixRow < RW'(2)) || (pixCol < CW'(2));

      de2_q     <= de1_q;
      vs2_q     <= vs1_q;
      data2_q   <= data1_q;
      border2_q <= border1_q;
      gx_q      <= gx_d;
      gy_q      <= gy_d;

      de3_q     <= de2_q;
      vs3_q     <= vs2_q;
      data3_q   <= data2_q;
      border3_q <= border2_q;
      absX_q    <= AW'(gx_q[GW-1] ? -gx_q : gx_q);
      absY_q    <= AW'(gy_q[GW-1] ? -gy_q : gy_q);

      oDe_q   <= de3_q;
      oVs_q   <= vs3_q;
      oEdge_q <= de3_q & ~border3_q & edgeHit;
      if (border3_q) begin
        oData_q <= data3_q;
      end else begin
        case (bus.mode)
          2'd1:    oData_q <= satMag;
          2'd2:    oData_q <= data3_q;
          default: oData_q <= (edgeHit ^ bus.invert) ? '0 : '1;
        endcase
      end
    end
  end

  assign bus.o_data = oData_q;
  assign bus.o_edge = oEdge_q;
  assign bus.o_de   = oDe_q;
  assign bus.o_vs   = oVs_q;
endmodule
